// File: rtl/data_port_responder_if.sv
// data_port_responder_if
//   Groups the request/response bus and the TX FIFO stream of the data port
//   responder into one bundle. Clock and reset stay outside as plain ports.
//
//   Handshake rules for this bundle:
//   - The requester raises req together with we, bh, addr and wdata, and keeps
//     them stable until it sees ready=1.
//   - ready is a single-cycle completion pulse. rdata is only meaningful while
//     ready=1 and is 0x0000 otherwise.
//   - The TX stream follows valid/ready rules. A byte leaves the FIFO on every
//     clock edge where tx_valid and tx_ready are both 1. tx_data is the head
//     byte, and it is 0x00 while tx_valid=0.
//
//   Signals:
//     req, we, bh, addr[15:0], wdata[15:0]  requester -> responder
//     rdata[15:0], ready                    responder -> requester
//     tx_valid, tx_data[7:0]                responder -> downstream
//     tx_ready                              downstream -> responder
//     dbg_state[2:0]                        responder FSM state, for observation only
interface data_port_responder_if;
    logic        req;
    logic        we;
    logic        bh;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [2:0]  dbg_state;

    modport slave (
        input  req, we, bh, addr, wdata, tx_ready,
        output rdata, ready, tx_valid, tx_data, dbg_state
    );

    modport master (
        output req, we, bh, addr, wdata, tx_ready,
        input  rdata, ready, tx_valid, tx_data, dbg_state
    );
endinterface

// File: rtl/data_port_responder.sv
// data_port_responder
//   This is a single-request memory-mapped responder. It serves a 128-byte
//   little-endian RAM and three registers:
//     0x0000-0x007F  RAM. Halfword accesses ignore addr[0].
//     0xFF00         TXDATA. A write pushes wdata[7:0] into a 4-deep FWFT FIFO.
//                    A read returns 0x0000.
//     0xFF02         STATUS = {10'b0, count[2:0], ovf, full, empty}.
//                    Any write to it clears ovf.
//     0xFF04         CYCLE. A free-running 16-bit counter, read-only.
//   Any other address completes normally: reads return 0x0000 and writes are
//   ignored.
//
//   Access sequence: IDLE -> ACCESS -> DONE -> IDLE. ready is high in DONE.
//   If DATA_PORT_WAIT_STATE_EN is defined, IDLE -> WAIT1 -> WAIT2 -> ACCESS
//   instead. This adds two cycles of latency. The address map and the FIFO
//   behave the same in both builds.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    data_port_responder_if.slave (request bus + TX stream + debug state)
module data_port_responder (
    input  logic                        clk,
    input  logic                        reset,
    data_port_responder_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT1  = 3'd1,
        S_WAIT2  = 3'd2,
        S_ACCESS = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Request captured in IDLE and held for the whole access
    logic        r_we;
    logic        r_bh;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    logic [15:0] r_rdata;
    logic [15:0] r_cycle;
    logic [7:0]  r_mem [128];

    logic [7:0]  r_fifo [4];
    logic [1:0]  r_rd_ptr;
    logic [1:0]  r_wr_ptr;
    logic [2:0]  r_count;
    logic        r_ovf;

    logic        w_access;
    logic        w_is_ram;
    logic        w_is_tx;
    logic        w_is_stat;
    logic        w_is_cyc;
    logic [6:0]  w_lo_idx;
    logic [6:0]  w_hi_idx;
    logic [15:0] w_rd_full;
    logic [15:0] w_rd_val;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_push_ok;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
`ifdef DATA_PORT_WAIT_STATE_EN
                    w_state_nxt = S_WAIT1;
`else
                    w_state_nxt = S_ACCESS;
`endif
                end
            end
            S_WAIT1:  w_state_nxt = S_WAIT2;
            S_WAIT2:  w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // The request is sampled only in IDLE. A req seen in any other state is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_bh    <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
        end else if (r_state == S_IDLE && bus.req) begin
            r_we    <= bus.we;
            r_bh    <= bus.bh;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
        end
    end

    // ------------------------------------------------------------------
    // Address decode. All side effects happen at the edge that ends ACCESS.
    // ------------------------------------------------------------------
    assign w_access  = (r_state == S_ACCESS);
    assign w_is_ram  = (r_addr[15:7] == 9'd0);
    assign w_is_tx   = (r_addr == 16'hFF00);
    assign w_is_stat = (r_addr == 16'hFF02);
    assign w_is_cyc  = (r_addr == 16'hFF04);

    // A halfword access always uses the even/odd byte pair.
    // A byte access uses the exact byte that was addressed.
    assign w_lo_idx  = r_bh ? {r_addr[6:1], 1'b0} : r_addr[6:0];
    assign w_hi_idx  = {r_addr[6:1], 1'b1};

    // RAM has no reset. Reset forces the FSM out of ACCESS asynchronously,
    // so an aborted write never reaches the array.
    always_ff @(posedge clk) begin
        if (w_access && r_we && w_is_ram) begin
            r_mem[w_lo_idx] <= r_wdata[7:0];
            if (r_bh) begin
                r_mem[w_hi_idx] <= r_wdata[15:8];
            end
        end
    end

    always_comb begin
        w_rd_full = 16'h0000;
        if (w_is_ram) begin
            w_rd_full = {r_mem[w_hi_idx], r_mem[w_lo_idx]};
        end else if (w_is_stat) begin
            w_rd_full = {10'b0, r_count, r_ovf, w_full, w_empty};
        end else if (w_is_cyc) begin
            w_rd_full = r_cycle;
        end
        // A byte read returns only the low byte of the selected location.
        w_rd_val = r_bh ? w_rd_full : {8'h00, w_rd_full[7:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= 16'h0000;
        end else if (w_access) begin
            r_rdata <= r_we ? 16'h0000 : w_rd_val;
        end
    end

    assign bus.ready     = (r_state == S_DONE);
    assign bus.rdata     = (r_state == S_DONE) ? r_rdata : 16'h0000;
    assign bus.dbg_state = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle <= 16'h0000;
        end else begin
            r_cycle <= r_cycle + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO: 4 entries, first-word fall-through
    // ------------------------------------------------------------------
    assign w_empty   = (r_count == 3'd0);
    assign w_full    = (r_count == 3'd4);
    assign w_push    = w_access && r_we && w_is_tx;
    assign w_pop     = bus.tx_ready && !w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_fifo[i] <= 8'h00;
            end
            r_rd_ptr <= 2'd0;
            r_wr_ptr <= 2'd0;
            r_count  <= 3'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_fifo[r_wr_ptr] <= r_wdata[7:0];
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_access && r_we && w_is_stat) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.tx_valid = !w_empty;
    assign bus.tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_data_port_responder.sv
// tb_data_port_responder
//   This bench exercises data_port_responder with directed and randomized
//   accesses. The reference model holds the RAM as a byte array and the TX
//   FIFO as a queue. It also keeps a plain edge counter for CYCLE.
//   Every comparison is an immediate assertion.
module tb_data_port_responder;

`ifdef DATA_PORT_WAIT_STATE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_port_responder_if bus();

    data_port_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [7:0]  m_mem [0:127];
    logic [7:0]  m_fifo [$];
    logic        m_ovf;
    logic [31:0] tb_cyc;

    // Counts the clock edges seen since reset was released.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] m_status();
        int n;
        n = m_fifo.size();
        return {10'b0, n[2:0], m_ovf, (n == 4), (n == 0)};
    endfunction

    function automatic logic [15:0] m_read(input logic bh, input logic [15:0] a);
        logic [15:0] v;
        logic [15:0] s;
        v = 16'h0000;
        if (a < 16'h0080) begin
            if (bh) v = {m_mem[{a[6:1], 1'b1}], m_mem[{a[6:1], 1'b0}]};
            else    v = {8'h00, m_mem[a[6:0]]};
        end else if (a == 16'hFF02) begin
            s = m_status();
            v = bh ? s : {8'h00, s[7:0]};
        end
        return v;
    endfunction

    function automatic void m_write(input logic bh, input logic [15:0] a, input logic [15:0] d);
        if (a < 16'h0080) begin
            if (bh) begin
                m_mem[{a[6:1], 1'b0}] = d[7:0];
                m_mem[{a[6:1], 1'b1}] = d[15:8];
            end else begin
                m_mem[a[6:0]] = d[7:0];
            end
        end else if (a == 16'hFF00) begin
            if (m_fifo.size() < 4) m_fifo.push_back(d[7:0]);
            else                   m_ovf = 1'b1;
        end else if (a == 16'hFF02) begin
            m_ovf = 1'b0;
        end
    endfunction

    task automatic start_req(input logic we, input logic bh, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = we;
        bus.bh    = bh;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    // The next rising edge is the one that samples req. tx_ready is pulsed
    // during the cycle pop_at cycles after that edge (pop_at < 0 means no pulse).
    // lat reports how many edges after the sampling edge ready was first seen.
    task automatic wait_ready(input int pop_at, output logic [15:0] rd, output int lat,
                              output logic [31:0] cyc_n);
        rd    = 'x;
        lat   = -1;
        cyc_n = 0;
        @(posedge clk);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (j == 0) cyc_n = tb_cyc;
            bus.tx_ready = (j == pop_at);
            if (bus.ready) begin
                rd      = bus.rdata;
                lat     = j + 1;
                bus.req = 1'b0;
                break;
            end
        end
        bus.tx_ready = 1'b0;
        bus.req      = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic we, input logic bh, input logic [15:0] a,
                        input logic [15:0] d, input int pop_at, output logic [15:0] rd);
        int          lat;
        logic [31:0] cyc_n;
        logic [31:0] cyc_exp;
        start_req(we, bh, a, d);
        wait_ready(pop_at, rd, lat, cyc_n);
        chk({tag, "_lat"}, lat, LAT);
        if (we) begin
            chk({tag, "_wr_rdata"}, {16'h0, rd}, 32'h0);
            if (pop_at >= 0 && a == 16'hFF00) begin
                if (m_fifo.size() != 0) void'(m_fifo.pop_front());
                m_fifo.push_back(d[7:0]);
            end else begin
                m_write(bh, a, d);
            end
        end else if (a == 16'hFF04) begin
            cyc_exp = cyc_n + LAT - 2;
            chk({tag, "_cycle"}, {16'h0, rd}, {16'h0, (bh ? cyc_exp[15:0] : {8'h00, cyc_exp[7:0]})});
        end else begin
            chk({tag, "_rd"}, {16'h0, rd}, {16'h0, m_read(bh, a)});
        end
    endtask

    task automatic pop_one(input string tag);
        @(negedge clk);
        chk({tag, "_tx_valid"}, {31'h0, bus.tx_valid}, {31'h0, (m_fifo.size() != 0)});
        chk({tag, "_tx_data"}, {24'h0, bus.tx_data}, {24'h0, (m_fifo.size() != 0) ? m_fifo[0] : 8'h00});
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        if (m_fifo.size() != 0) void'(m_fifo.pop_front());
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] a;
        int          lat;
        logic [31:0] cyc_n;

        bus.req = 1'b0; bus.we = 1'b0; bus.bh = 1'b0;
        bus.addr = 16'h0; bus.wdata = 16'h0; bus.tx_ready = 1'b0;
        m_ovf = 1'b0;
        reset = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready",    {31'h0, bus.ready},    32'h0);
        chk("rst_rdata",    {16'h0, bus.rdata},    32'h0);
        chk("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        chk("rst_tx_data",  {24'h0, bus.tx_data},  32'h0);
        reset = 1'b0;

        // Fill the RAM so every later read has a defined expectation
        for (int i = 0; i < 128; i += 2) begin
            a = 16'(i);
            xfer("init", 1'b1, 1'b1, a, 16'($urandom_range(0, 65535)), -1, rd);
        end

        // Halfword write/read, then a byte read of the upper byte
        xfer("hw_wr", 1'b1, 1'b1, 16'h0010, 16'hBEEF, -1, rd);
        xfer("hw_rd", 1'b0, 1'b1, 16'h0010, 16'h0000, -1, rd);
        chk("beef", {16'h0, rd}, 32'h0000BEEF);
        xfer("b_rd", 1'b0, 1'b0, 16'h0011, 16'h0000, -1, rd);
        chk("00be", {16'h0, rd}, 32'h000000BE);

        // A byte write must change only the byte it addresses
        xfer("b_wr", 1'b1, 1'b0, 16'h0011, 16'hC35A, -1, rd);
        xfer("hw_rd2", 1'b0, 1'b1, 16'h0010, 16'h0000, -1, rd);
        chk("5aef", {16'h0, rd}, 32'h00005AEF);

        // Randomized RAM and unmapped traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(16'h0080, 16'hFEFF));
            else                           a = 16'($urandom_range(0, 127));
            xfer("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                 16'($urandom_range(0, 65535)), -1, rd);
        end

        // Overflow: five pushes with no pop
        xfer("st0", 1'b0, 1'b1, 16'hFF02, 16'h0, -1, rd);
        chk("status_empty", {16'h0, rd}, 32'h0001);
        for (int i = 0; i < 5; i++) begin
            xfer("push", 1'b1, 1'b1, 16'hFF00, 16'($urandom_range(0, 65535)), -1, rd);
        end
        xfer("st_ovf", 1'b0, 1'b1, 16'hFF02, 16'h0, -1, rd);
        chk("status_0026", {16'h0, rd}, 32'h0026);
        xfer("txd_rd", 1'b0, 1'b1, 16'hFF00, 16'h0, -1, rd);
        xfer("st_clr", 1'b1, 1'b1, 16'hFF02, 16'($urandom_range(0, 65535)), -1, rd);
        xfer("st_after", 1'b0, 1'b1, 16'hFF02, 16'h0, -1, rd);
        chk("status_0022", {16'h0, rd}, 32'h0022);

        // FIFO is full; push 0x77 in the same cycle as a pop
        xfer("push_pop", 1'b1, 1'b1, 16'hFF00, 16'h0077, LAT - 2, rd);
        xfer("st_pp", 1'b0, 1'b1, 16'hFF02, 16'h0, -1, rd);
        chk("status_pp", {16'h0, rd}, 32'h0022);
        for (int i = 0; i < 4; i++) pop_one("drain");
        pop_one("empty_pop");
        xfer("st_drained", 1'b0, 1'b1, 16'hFF02, 16'h0, -1, rd);
        chk("status_drained", {16'h0, rd}, 32'h0001);

        // Unmapped read, then a CYCLE read before and after the counter wraps
        xfer("unmapped", 1'b0, 1'b1, 16'h0100, 16'h0, -1, rd);
        chk("unmapped_zero", {16'h0, rd}, 32'h0);
        xfer("cyc1", 1'b0, 1'b1, 16'hFF04, 16'h0, -1, rd);
        repeat (65536 + 37) @(posedge clk);
        xfer("cyc2", 1'b0, 1'b1, 16'hFF04, 16'h0, -1, rd);

        // Reset in the middle of a write to 0x0000; req is held across reset release
        xfer("pre_push", 1'b1, 1'b1, 16'hFF00, 16'h00A5, -1, rd);
        start_req(1'b1, 1'b1, 16'h0000, 16'h1234);
        @(posedge clk);
        repeat (LAT - 2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_fifo.delete();
        m_ovf = 1'b0;
        #1;
        chk("abort_ready",    {31'h0, bus.ready},    32'h0);
        chk("abort_rdata",    {16'h0, bus.rdata},    32'h0);
        chk("abort_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        chk("abort_tx_data",  {24'h0, bus.tx_data},  32'h0);
        bus.we = 1'b0;
        @(negedge clk);
        chk("abort_ready2", {31'h0, bus.ready}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_ready(-1, rd, lat, cyc_n);
        chk("held_req_lat", lat, LAT);
        chk("ram0_kept", {16'h0, rd}, {16'h0, m_read(1'b1, 16'h0000)});
        xfer("st_rst", 1'b0, 1'b1, 16'hFF02, 16'h0, -1, rd);
        chk("status_rst", {16'h0, rd}, 32'h0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_port_responder.md
DATA_PORT_RESPONDER -- requirements
Module: data_port_responder

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port req  input  1  access request, level, held by requester until ready seen.
REQ-004 SHALL have port we  input  1  1=write, 0=read.
REQ-005 SHALL have port bh  input  1  1=halfword, 0=byte access.
REQ-006 SHALL have port addr  input  16  byte address.
REQ-007 SHALL have port wdata  input  16  write data; byte writes use wdata[7:0].
REQ-008 SHALL have port rdata  output  16  read data, valid only while ready=1.
REQ-009 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port tx_valid  output  1  TX FIFO non-empty.
REQ-011 SHALL have port tx_data  output  8  TX FIFO head byte.
REQ-012 SHALL have port tx_ready  input  1  downstream pop; pop occurs when tx_valid & tx_ready.

Function
REQ-013 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; with WAIT_STATE_EN, IDLE -> WAIT1 -> WAIT2 -> ACCESS.
REQ-014 SHALL, in IDLE with req=1, latch addr, we, bh, wdata and leave IDLE next edge; req in any other state ignored.
REQ-015 SHALL commit writes and register read data only at the end of the ACCESS cycle.
REQ-016 SHALL assert ready=1 exactly in DONE, rdata=0x0000 outside DONE and for writes.
REQ-017 SHALL give latency: req sampled at edge N -> ready high in cycle N+2 (N+4 with WAIT_STATE_EN).
REQ-018 SHALL map 0x0000-0x007F to 128-byte RAM, little-endian; halfword accesses ignore addr[0].
REQ-019 SHALL return byte reads as {8'h00, byte}; byte writes modify only the addressed byte.
REQ-020 SHALL map 0xFF00 TXDATA: write pushes wdata[7:0]; read returns 0x0000.
REQ-021 SHALL map 0xFF02 STATUS read {10'b0, count[2:0], ovf, full, empty}; any write clears ovf.
REQ-022 SHALL map 0xFF04 CYCLE: read-only free-running 16-bit counter, +1 every clock, wraps 0xFFFF->0x0000, value sampled in ACCESS cycle.
REQ-023 SHALL ack all other addresses normally: reads 0x0000, writes ignored.
REQ-024 SHALL implement TX FIFO depth 4, first-word fall-through, count 0..4.
REQ-025 SHALL, on push when full with no same-cycle pop, drop the byte and set ovf (sticky).
REQ-026 SHALL, on simultaneous push and pop, perform both; count unchanged; push to a full FIFO with same-cycle pop is accepted.
REQ-027 SHALL ignore pop when empty; tx_data=0x00 when empty.

Reset
REQ-028 SHALL on reset force state IDLE, ready=0, rdata=0, FIFO empty, count=0, ovf=0, tx_valid=0, tx_data=0, CYCLE=0.
REQ-029 SHALL abort an in-flight access on reset with no write committed and no ready pulse; RAM contents not reset.
REQ-030 SHALL, after reset deassertion, accept a held req on the first clock edge.

Configuration
REQ-031 SHALL use macro DATA_PORT_WAIT_STATE_EN: defined -> states WAIT1/WAIT2 inserted, latency 4; undefined -> no WAIT states, latency 2; address map and FIFO behaviour identical.

Verification
REQ-032 SHALL test: halfword write 0xBEEF to 0x0010, then halfword read 0x0010 -> rdata=0xBEEF; byte read 0x0011 -> 0x00BE; ready at N+2 (N+4 with macro).
REQ-033 SHALL test: byte write 0x5A to 0x0011 over 0xBEEF -> halfword read 0x0010 = 0x5AEF.
REQ-034 SHALL test: 5 pushes to 0xFF00 with tx_ready=0 -> STATUS=0x0026 (count 4, ovf, full); write STATUS -> 0x0022.
REQ-035 SHALL test: FIFO full, push 0x77 same cycle as pop -> count stays 4, 0x77 at tail, ovf unchanged.
REQ-036 SHALL test: reset asserted during ACCESS of write 0x1234 to 0x0000 -> no ready, RAM[0x0000] unchanged, all outputs zero.
REQ-037 SHALL test: read 0x0100 -> rdata=0x0000 with ready; CYCLE read after 65536+k clocks wraps to k-relative value.
